fifo_rd_ctrl: RTL

Read-side controller for the async FIFO, in the rclk domain; the memory write port lives in the wclk domain.
- Synchronises the write-domain Gray write pointer into rclk.
- Maintains the read pointer (binary and Gray), generates rempty and drives the memory read address.
- Presents data through a first-word-fall-through (FWFT) output register with a valid/ready handshake.

---
 rtl/fifo_pkg.sv | 44 ++++
 rtl/fifo_sync2.sv | 34 +++
 rtl/fifo_rd_ctrl.sv | 130 +++++++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
// Shared definitions for the async FIFO read and write controllers.
//   FIFO_DATASIZE / FIFO_ADDRSIZE : default word and address widths
//   bin2gray / gray2bin           : pointer code conversions. Both operate on a
//                                   GRAY_MAXW-bit container. The value is
//                                   masked to 'width' bits, so narrower
//                                   pointers are zero-extended on the way in
//                                   and size-cast on the way out.
// -----------------------------------------------------------------------------
package fifo_pkg;

    localparam int FIFO_DATASIZE = 8;
    localparam int FIFO_ADDRSIZE = 4;
    localparam int GRAY_MAXW     = 32;

    // Build a mask of 'width' ones. A width of GRAY_MAXW shifts the 1 out,
    // and the subtraction then wraps to all ones.
    function automatic logic [GRAY_MAXW-1:0] width_mask(input int unsigned width);
        return (32'd1 << width) - 32'd1;
    endfunction

    // Convert a binary value to Gray code.
    function automatic logic [GRAY_MAXW-1:0] bin2gray(input logic [GRAY_MAXW-1:0] bin,
                                                      input int unsigned          width);
        logic [GRAY_MAXW-1:0] b;
        b = bin & width_mask(width);
        return b ^ (b >> 1);
    endfunction

    // Convert Gray code to binary by prefix-XOR from the MSB down.
    function automatic logic [GRAY_MAXW-1:0] gray2bin(input logic [GRAY_MAXW-1:0] gray,
                                                      input int unsigned          width);
        logic [GRAY_MAXW-1:0] g;
        logic [GRAY_MAXW-1:0] b;
        g = gray & width_mask(width);
        b[GRAY_MAXW-1] = g[GRAY_MAXW-1];
        for (int i = GRAY_MAXW - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/fifo_sync2.sv
// -----------------------------------------------------------------------------
// fifo_sync2
// Two-flop synchroniser for a Gray-coded pointer crossing clock domains.
// This module is shared by the read-side and write-side controllers.
//   clk : destination clock
//   rst : synchronous reset, active-high (clears both stages)
//   d   : asynchronous input bus
//   q   : synchronised output (second stage)
// -----------------------------------------------------------------------------
module fifo_sync2
    import fifo_pkg::*;
#(
    parameter int WIDTH = FIFO_ADDRSIZE + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q1_r;

    // The first stage may go metastable. Only the second stage is used downstream.
    always_ff @(posedge clk) begin
        if (rst) begin
            q1_r <= {WIDTH{1'b0}};
            q    <= {WIDTH{1'b0}};
        end else begin
            q1_r <= d;
            q    <= q1_r;
        end
    end

endmodule

// File: rtl/fifo_rd_ctrl.sv
// -----------------------------------------------------------------------------
// fifo_rd_ctrl
// Read-side controller of the async FIFO (rclk domain). It synchronises the
// write pointer, keeps the read pointer in binary and Gray, flags empty, and
// presents data through a first-word-fall-through output register.
//
// Ports:
//   rclk       : read clock
//   rrst       : synchronous reset, active-high
//   wptr_gray  : Gray write pointer from the wclk domain (asynchronous)
//   rptr_gray  : registered Gray read pointer to the write domain
//   raddr      : memory read address
//   mem_rdata  : combinational memory read data at raddr
//   dout       : output data register
//   dout_valid : dout holds a valid word
//   dout_ready : consumer accepts dout this cycle
//   rempty     : memory holds no unread word (output register excluded)
//
// Optional feature (macro FIFO_RD_LEVEL_EN):
//   rlevel     : synchronised word count in memory (output register excluded)
//   raempty    : rlevel <= AEMPTY_THRESH
// -----------------------------------------------------------------------------
module fifo_rd_ctrl
    import fifo_pkg::*;
#(
    parameter int DATASIZE = FIFO_DATASIZE,
    parameter int ADDRSIZE = FIFO_ADDRSIZE
`ifdef FIFO_RD_LEVEL_EN
    ,
    parameter int AEMPTY_THRESH = 2
`endif
) (
    input  logic                rclk,
    input  logic                rrst,
    input  logic [ADDRSIZE:0]   wptr_gray,
    output logic [ADDRSIZE:0]   rptr_gray,
    output logic [ADDRSIZE-1:0] raddr,
    input  logic [DATASIZE-1:0] mem_rdata,
    output logic [DATASIZE-1:0] dout,
    output logic                dout_valid,
    input  logic                dout_ready,
`ifdef FIFO_RD_LEVEL_EN
    output logic [ADDRSIZE:0]   rlevel,
    output logic                raempty,
`endif
    output logic                rempty
);

    localparam int PTRSIZE = ADDRSIZE + 1;

    logic [PTRSIZE-1:0] rq2_s;
    logic [PTRSIZE-1:0] rbin_r;
    logic [PTRSIZE-1:0] rbinnext_s;
    logic [PTRSIZE-1:0] rgraynext_s;
    logic               rinc_s;

    fifo_sync2 #(
        .WIDTH (PTRSIZE)
    ) u_wptr_sync (
        .clk (rclk),
        .rst (rrst),
        .d   (wptr_gray),
        .q   (rq2_s)
    );

    assign raddr = rbin_r[ADDRSIZE-1:0];

    // Read strobe and next pointers. A word is fetched when memory holds one and
    // the output register is empty or is being drained on this edge.
    always_comb begin
        rinc_s      = !rempty && (!dout_valid || dout_ready);
        rbinnext_s  = rbin_r + {{ADDRSIZE{1'b0}}, rinc_s};
        rgraynext_s = PTRSIZE'(bin2gray(GRAY_MAXW'(rbinnext_s), PTRSIZE));
    end

    // Read pointers and empty flag. Empty compares against the synchronised
    // write pointer, so it clears only after the synchroniser delay.
    always_ff @(posedge rclk) begin
        if (rrst) begin
            rbin_r    <= {PTRSIZE{1'b0}};
            rptr_gray <= {PTRSIZE{1'b0}};
            rempty    <= 1'b1;
        end else begin
            rbin_r    <= rbinnext_s;
            rptr_gray <= rgraynext_s;
            rempty    <= (rgraynext_s == rq2_s);
        end
    end

    // FWFT output register. A reload takes precedence over a drain, so a word
    // that is accepted while another is fetched gives one word per cycle.
    always_ff @(posedge rclk) begin
        if (rrst) begin
            dout       <= {DATASIZE{1'b0}};
            dout_valid <= 1'b0;
        end else if (rinc_s) begin
            dout       <= mem_rdata;
            dout_valid <= 1'b1;
        end else if (dout_ready && dout_valid) begin
            dout       <= dout;
            dout_valid <= 1'b0;
        end else begin
            dout       <= dout;
            dout_valid <= dout_valid;
        end
    end

`ifdef FIFO_RD_LEVEL_EN
    logic [PTRSIZE-1:0] wbin_sync_s;
    logic [PTRSIZE-1:0] level_s;

    // Words left in memory after this edge's read, modulo the pointer range.
    always_comb begin
        wbin_sync_s = PTRSIZE'(gray2bin(GRAY_MAXW'(rq2_s), PTRSIZE));
        level_s     = wbin_sync_s - rbinnext_s;
    end

    // Registered level and almost-empty flag.
    always_ff @(posedge rclk) begin
        if (rrst) begin
            rlevel  <= {PTRSIZE{1'b0}};
            raempty <= 1'b1;
        end else begin
            rlevel  <= level_s;
            raempty <= (level_s <= PTRSIZE'(AEMPTY_THRESH));
        end
    end
`endif

endmodule
